// File: rtl/hack_mem_responder_pkg.sv
// Hack data-memory responder: shared constants,
// region type and address decode helper.
package hack_mem_pkg;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;
  localparam int          SCR_AW      = 13;
  localparam int          SCR_EW      = SCR_AW + 16;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  function automatic region_e decode(
    input logic [14:0] a
  );
    region_e r;
    r = REG_NONE;
    unique case (1'b1)
      !a[14]:              r = REG_RAM;
      a[14:13] == 2'b10:   r = REG_SCREEN;
      a == KBD_ADDR:       r = REG_KBD;
      default:             r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hack_mem_responder_if.sv
// CPU data port, keyboard link and
// screen-write link of the responder.
interface hack_mem_responder_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        scr_overflow;

  modport master (
    output addressM, outM, writeM,
    output kbd_valid, kbd_code, scr_ready,
    input  inM, kbd_ready,
    input  scr_valid, scr_addr, scr_data,
    input  scr_overflow
  );

  modport slave (
    input  addressM, outM, writeM,
    input  kbd_valid, kbd_code, scr_ready,
    output inM, kbd_ready,
    output scr_valid, scr_addr, scr_data,
    output scr_overflow
  );
endinterface

// File: rtl/hack_mem_responder_scr_write_fifo.sv
// Small synchronous FIFO for screen writes;
// accepts a push while full if it also pops.
module scr_write_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // storage is not cleared; empty gates the head
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/hack_mem_responder.sv
// Hack data-memory responder: RAM, screen shadow
// with write FIFO, and keyboard register.
module hack_mem_responder
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  hack_mem_responder_if.slave  bus
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int SAW = $clog2(SCREEN_WORDS);

  logic [15:0]       ram_q [RAM_WORDS];
  logic [15:0]       shd_q [SCREEN_WORDS];
  logic [15:0]       kbd_q;
  logic              ovf_q;
  region_e           rgn;
  logic              push, pop;
  logic              full, empty;
  logic [SCR_EW-1:0] head;

  assign rgn  = decode(bus.addressM);
  assign push = bus.writeM && (rgn == REG_SCREEN)
             && !reset;
  assign pop  = bus.scr_valid && bus.scr_ready;

  assign bus.kbd_ready    = !reset;
  assign bus.scr_valid    = !empty;
  assign bus.scr_addr     = head[SCR_EW-1:16];
  assign bus.scr_data     = head[15:0];
  assign bus.scr_overflow = ovf_q;

  // zero-latency read mux
  always_comb begin
    bus.inM = '0;
    unique case (rgn)
      REG_RAM:    bus.inM = ram_q[bus.addressM[RAW-1:0]];
      REG_SCREEN: bus.inM = shd_q[bus.addressM[SAW-1:0]];
      REG_KBD:    bus.inM = kbd_q;
      default:    bus.inM = '0;
    endcase
  end

  // RAM and shadow writes, also during reset
  always_ff @(posedge clk) begin
    if (bus.writeM && rgn == REG_RAM)
      ram_q[bus.addressM[RAW-1:0]] <= bus.outM;
    if (bus.writeM && rgn == REG_SCREEN)
      shd_q[bus.addressM[SAW-1:0]] <= bus.outM;
  end

  // keyboard register and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.kbd_valid) kbd_q <= bus.kbd_code;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  scr_write_fifo #(
    .W     (SCR_EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({bus.addressM[SCR_AW-1:0], bus.outM}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );
endmodule

// File: tb/tb_hack_mem_responder.sv
// Directed self-checking bench for
// hack_mem_responder.
module tb_hack_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  hack_mem_responder_if bus ();

  hack_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.addressM  = '0;
    bus.outM      = '0;
    bus.writeM    = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = '0;
    bus.scr_ready = 1'b0;
    step();
    #1;
    chk("rst_kbd_ready", 16'(bus.kbd_ready), 16'h0);
    step();
    reset = 1'b0;
    bus.addressM = 15'h6000;
    #1;
    chk("rst_scr_valid", 16'(bus.scr_valid), 16'h0);
    chk("rst_ovf", 16'(bus.scr_overflow), 16'h0);
    chk("rst_scr_addr", 16'(bus.scr_addr), 16'h0);
    chk("rst_scr_data", bus.scr_data, 16'h0);
    chk("rst_kbd_reg", bus.inM, 16'h0);
    chk("kbd_ready_on", 16'(bus.kbd_ready), 16'h1);

    // RAM write, old value visible same cycle
    bus.addressM = 15'h0010;
    bus.outM = 16'h1111;
    bus.writeM = 1'b1;
    step();
    bus.writeM = 1'b0;
    chk("ram_first", bus.inM, 16'h1111);
    bus.outM = 16'h1234;
    bus.writeM = 1'b1;
    #1;
    chk("ram_same_cycle", bus.inM, 16'h1111);
    step();
    bus.writeM = 1'b0;
    #1;
    chk("ram_next_cycle", bus.inM, 16'h1234);
    chk("ram_no_scr", 16'(bus.scr_valid), 16'h0);

    // single screen write and pop
    bus.addressM = 15'h4005;
    bus.outM = 16'hFFFF;
    bus.writeM = 1'b1;
    step();
    bus.writeM = 1'b0;
    #1;
    chk("scr1_valid", 16'(bus.scr_valid), 16'h1);
    chk("scr1_addr", 16'(bus.scr_addr), 16'h0005);
    chk("scr1_data", bus.scr_data, 16'hFFFF);
    chk("scr1_shadow", bus.inM, 16'hFFFF);
    bus.scr_ready = 1'b1;
    step();
    bus.scr_ready = 1'b0;
    #1;
    chk("scr1_empty", 16'(bus.scr_valid), 16'h0);
    chk("scr1_gated", bus.scr_data, 16'h0);

    // five writes into depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      bus.addressM = 15'h4010 + 15'(i);
      bus.outM = 16'hA000 + 16'(i);
      bus.writeM = 1'b1;
      step();
    end
    bus.writeM = 1'b0;
    #1;
    chk("ovf_set", 16'(bus.scr_overflow), 16'h1);
    for (int i = 0; i < 5; i++) begin
      bus.addressM = 15'h4010 + 15'(i);
      #1;
      chk("ovf_shadow", bus.inM, 16'hA000 + 16'(i));
    end
    bus.scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 16'(bus.scr_valid), 16'h1);
      chk("drain_addr", 16'(bus.scr_addr),
          16'h0010 + 16'(i));
      chk("drain_data", bus.scr_data,
          16'hA000 + 16'(i));
      step();
    end
    bus.scr_ready = 1'b0;
    #1;
    chk("drain_empty", 16'(bus.scr_valid), 16'h0);
    chk("ovf_sticky", 16'(bus.scr_overflow), 16'h1);

    // clear overflow, then push+pop while full
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("ovf_cleared", 16'(bus.scr_overflow), 16'h0);
    for (int i = 0; i < 4; i++) begin
      bus.addressM = 15'h4020 + 15'(i);
      bus.outM = 16'hB000 + 16'(i);
      bus.writeM = 1'b1;
      step();
    end
    bus.addressM = 15'h4024;
    bus.outM = 16'hC000;
    bus.scr_ready = 1'b1;
    step();
    bus.writeM = 1'b0;
    bus.scr_ready = 1'b0;
    #1;
    chk("pp_no_ovf", 16'(bus.scr_overflow), 16'h0);
    chk("pp_head", 16'(bus.scr_addr), 16'h0021);
    bus.scr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("pp_valid", 16'(bus.scr_valid), 16'h1);
      chk("pp_addr", 16'(bus.scr_addr),
          16'h0020 + 16'(i));
      chk("pp_data", bus.scr_data,
          (i == 4) ? 16'hC000 : 16'hB000 + 16'(i));
      step();
    end
    bus.scr_ready = 1'b0;
    #1;
    chk("pp_empty", 16'(bus.scr_valid), 16'h0);

    // keyboard
    bus.kbd_valid = 1'b1;
    bus.kbd_code = 16'h0041;
    step();
    bus.kbd_valid = 1'b0;
    bus.kbd_code = 16'h0055;
    bus.addressM = 15'h6000;
    #1;
    chk("kbd_read", bus.inM, 16'h0041);
    bus.outM = 16'h1234;
    bus.writeM = 1'b1;
    step();
    bus.writeM = 1'b0;
    #1;
    chk("kbd_hold", bus.inM, 16'h0041);
    bus.addressM = 15'h7000;
    #1;
    chk("unmapped_7000", bus.inM, 16'h0);
    bus.addressM = 15'h6001;
    #1;
    chk("unmapped_6001", bus.inM, 16'h0);

    // reset with 3 pending entries
    for (int i = 0; i < 3; i++) begin
      bus.addressM = 15'h4040 + 15'(i);
      bus.outM = 16'hD000 + 16'(i);
      bus.writeM = 1'b1;
      step();
    end
    bus.writeM = 1'b0;
    #1;
    chk("pend_valid", 16'(bus.scr_valid), 16'h1);
    reset = 1'b1;
    bus.addressM = 15'h0020;
    bus.outM = 16'h5555;
    bus.writeM = 1'b1;
    step();
    bus.addressM = 15'h4030;
    bus.outM = 16'h7777;
    step();
    reset = 1'b0;
    bus.writeM = 1'b0;
    #1;
    chk("rr_scr_valid", 16'(bus.scr_valid), 16'h0);
    chk("rr_ovf", 16'(bus.scr_overflow), 16'h0);
    chk("rr_shadow", bus.inM, 16'h7777);
    bus.addressM = 15'h6000;
    #1;
    chk("rr_kbd", bus.inM, 16'h0);
    bus.addressM = 15'h0010;
    #1;
    chk("rr_ram_kept", bus.inM, 16'h1234);
    bus.addressM = 15'h0020;
    #1;
    chk("rr_ram_wr", bus.inM, 16'h5555);
    step();
    chk("rr_no_push", 16'(bus.scr_valid), 16'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hack_mem_responder.md
# hack_mem_responder

Data-memory responder for the Hack CPU data port: serves the CPU's `addressM`/`outM`/`writeM` accesses and returns `inM`. Decodes the 32K word address space into RAM, screen and keyboard regions. Screen writes update a local shadow memory and are queued in a small FIFO toward an external display controller over a valid/ready link. Keyboard codes arrive over a valid/ready link into the keyboard register.

## Interface
Parameters:
- `RAM_WORDS`, 16384 — general RAM words, addresses 0x0000–0x3FFF.
- `SCREEN_WORDS`, 8192 — screen shadow words, addresses 0x4000–0x5FFF.
- `FIFO_DEPTH`, 4 — screen-write FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `addressM`  in  15  — CPU data address.
- `outM`  in  16  — CPU write data.
- `writeM`  in  1  — CPU write strobe; the write commits at the rising edge.
- `inM`  out  16  — read data for `addressM`, combinational, same cycle.
- `kbd_valid`  in  1  — a keyboard code is offered.
- `kbd_code`  in  16  — scan code; 0 means no key pressed.
- `kbd_ready`  out  1  — the keyboard code is accepted when this is high.
- `scr_valid`  out  1  — the FIFO head holds a screen write.
- `scr_addr`  out  13  — screen word offset of the head entry.
- `scr_data`  out  16  — data of the head entry.
- `scr_ready`  in  1  — the display consumes the head entry.
- `scr_overflow`  out  1  — sticky flag: at least one screen write was dropped.

## Operation
Address decode:
- 0x0000–0x3FFF: RAM.
- 0x4000–0x5FFF: screen shadow.
- 0x6000: keyboard.
- 0x6001–0x7FFF: unmapped.

Reads:
- `inM` = selected word.
- Keyboard address returns the keyboard register.
- Unmapped addresses return 0.

Writes (when `writeM`=1):
- RAM and screen shadow are written at the edge.
- A screen write also pushes {offset, `outM`} into the FIFO.
- Writes to keyboard or unmapped addresses are ignored.

Keyboard:
- `kbd_ready` = !reset.
- On `kbd_valid`&&`kbd_ready`, the keyboard register takes `kbd_code`.
- With no new transfer, the register holds its value.

Screen FIFO:
- Pop on `scr_valid`&&`scr_ready`.
- Head fields are stable while `scr_valid`=1 and `scr_ready`=0.
- Full FIFO and screen write, with no pop that cycle: the shadow is still written, the FIFO entry is dropped, and `scr_overflow` sets. It clears only on reset.
- Full FIFO with a pop and a push in the same cycle: both occur, no overflow.
- Entries leave in push order.

## Timing
- Read latency 0: `inM` is combinational on `addressM`.
- A write is visible to reads from the cycle after the edge. A same-cycle read of the written address returns the old value.
- Push into an empty FIFO: `scr_valid`=1 in the following cycle.
- Keyboard transfer: the new code is readable at 0x6000 the cycle after acceptance.
- Reset values:
  - `scr_valid`=0, `scr_overflow`=0.
  - `scr_addr`/`scr_data`=0 (FIFO storage not cleared; head outputs gated to 0 when empty).
  - Keyboard register 0.
  - `kbd_ready`=0 during reset.
- RAM and shadow contents are not cleared.
- Reset mid-operation: all pending FIFO entries are discarded. A `writeM` in a reset cycle still writes RAM/shadow but does not push.

## Structure
Package `hack_mem_pkg`:
- `SCREEN_BASE`=15'h4000, `KBD_ADDR`=15'h6000.
- Region enum {`REG_RAM`, `REG_SCREEN`, `REG_KBD`, `REG_NONE`} and the decode function.

Sub-module `scr_write_fifo`:
- Synchronous FIFO, width 29, depth `FIFO_DEPTH`.
- Push/pop, full/empty; simultaneous push+pop supported when full.

The top holds RAM, shadow, keyboard register, decode and overflow flag.

## Test plan
- RAM write 0x1234 to 0x0010 with `writeM`=1 → same cycle `inM`=old value; next cycle `inM`=0x1234; `scr_valid` stays 0.
- Screen write 0xFFFF to 0x4005 → next cycle `scr_valid`=1, `scr_addr`=5, `scr_data`=0xFFFF; read 0x4005 returns 0xFFFF; `scr_ready`=1 pops the entry and the FIFO is empty.
- Five consecutive screen writes with `scr_ready`=0, depth 4 → first four queued in order, fifth dropped, `scr_overflow`=1, shadow holds all five; draining yields exactly four entries.
- FIFO full, screen write and `scr_ready`=1 in the same cycle → no overflow, count stays 4, order preserved.
- `kbd_valid`=1, `kbd_code`=0x0041 → next cycle a read of 0x6000 returns 0x0041; a write to 0x6000 does not change it; a read of 0x7000 returns 0.
- Reset asserted with 3 FIFO entries pending → next cycle `scr_valid`=0, `scr_overflow`=0, read of 0x6000 returns 0; RAM data from before reset is still readable.
